// File: rtl/neur_pkg.sv
// Shared constants and types for the neuron multiplier arbiter.
//   NEUR_NLANES / NEUR_OPW / NEUR_PRODW : default array geometry
//   arb_state_e                         : arbiter FSM states
//   mul_id_t                            : owner tag carried with each in-flight beat
package neur_pkg;

  localparam int unsigned NEUR_NLANES = 4;
  localparam int unsigned NEUR_OPW    = 17;
  localparam int unsigned NEUR_PRODW  = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BURST0,
    ARB_BEAT1
  } arb_state_e;

  typedef logic [0:0] mul_id_t;

  localparam mul_id_t ID_REQ0 = 1'b0;
  localparam mul_id_t ID_REQ1 = 1'b1;

  // Owner id to response-valid vector (bit0 = requester 0).
  function automatic logic [1:0] id_onehot(input mul_id_t id);
    return (id == ID_REQ1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/neur_mul_tag_pipe.sv
// MUL_LAT-deep delay line of {valid, id} tracking beats inside the multiplier array.
//   clk_i_fast : clock
//   rst_ni     : async active-low reset, drops every in-flight tag
//   in_vld     : beat issued this cycle
//   in_id      : owner of the issued beat
//   out_vld    : tag valid at depth MUL_LAT (product present on the array output)
//   out_id     : owner of that product
//   any_vld    : any tag still in flight
module neur_mul_tag_pipe #(
  parameter int unsigned MUL_LAT = 1
) (
  input  logic clk_i_fast,
  input  logic rst_ni,
  input  logic in_vld,
  input  logic in_id,
  output logic out_vld,
  output logic out_id,
  output logic any_vld
);

  logic [MUL_LAT-1:0] vld_q;
  logic [MUL_LAT-1:0] id_q;

  always_ff @(posedge clk_i_fast or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q <= (vld_q << 1) | MUL_LAT'(in_vld);
      id_q  <= (id_q << 1) | MUL_LAT'(in_id);
    end
  end

  assign out_vld = vld_q[MUL_LAT-1];
  assign out_id  = id_q[MUL_LAT-1];
  assign any_vld = |vld_q;

endmodule

// File: rtl/neur_mul_arbiter.sv
// Shares the NLANES-lane multiplier array between the requantization unit (requester 0,
// BURST0-beat locked bursts) and the core MAC/ALU path (requester 1, single beats).
// Products come back MUL_LAT+1 cycles after the grant, in issue order, tagged to their owner.
//   clk_i_fast, rst_ni      : clock, async active-low reset
//   req0_i, a0_i, b0_i      : requester 0 request and operands (lane 3 in MSBs)
//   gnt0_o                  : requester 0 beat issued this cycle
//   req1_i, a1_i, b1_i      : requester 1 request and operands
//   gnt1_o                  : requester 1 beat issued this cycle
//   mul_a_o, mul_b_o        : operands to the array (0 when idle)
//   mul_en_o                : valid beat presented to the array
//   mul_p_i                 : array products, MUL_LAT cycles after mul_en_o
//   rsp_p_o, rsp_vld_o      : registered products and one-hot owner (bit0 = requester 0)
//   busy_o                  : burst/beat open or any beat in flight
// Build option: NEUR_MUL_ARB_FIXED_PRIO_EN gives requester 0 absolute priority;
// otherwise contention is resolved round-robin.
module neur_mul_arbiter
  import neur_pkg::*;
#(
  parameter int unsigned NLANES  = NEUR_NLANES,
  parameter int unsigned OPW     = NEUR_OPW,
  parameter int unsigned PRODW   = NEUR_PRODW,
  parameter int unsigned MUL_LAT = 1,
  parameter int unsigned BURST0  = 2
) (
  input  logic                    clk_i_fast,
  input  logic                    rst_ni,
  input  logic                    req0_i,
  input  logic [NLANES*OPW-1:0]   a0_i,
  input  logic [NLANES*OPW-1:0]   b0_i,
  output logic                    gnt0_o,
  input  logic                    req1_i,
  input  logic [NLANES*OPW-1:0]   a1_i,
  input  logic [NLANES*OPW-1:0]   b1_i,
  output logic                    gnt1_o,
  output logic [NLANES*OPW-1:0]   mul_a_o,
  output logic [NLANES*OPW-1:0]   mul_b_o,
  output logic                    mul_en_o,
  input  logic [NLANES*PRODW-1:0] mul_p_i,
  output logic [NLANES*PRODW-1:0] rsp_p_o,
  output logic [1:0]              rsp_vld_o,
  output logic                    busy_o
);

  localparam logic [1:0] LastBeat = 2'(BURST0 - 1);

  arb_state_e state_q, state_d;
  logic [1:0] beat_cnt_q, beat_cnt_d;
  logic       last_beat;
  logic       arb_open;
  logic       win0;
  logic       win1;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef NEUR_MUL_ARB_FIXED_PRIO_EN
  assign win0 = req0_i;
`else
  logic rr_ptr_q, rr_ptr_d;

  // In the last beat the pointer already reflects the grant being completed, so the
  // owner handed over to is always the other requester under contention.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (last_beat) begin
      rr_ptr_d = (state_q == ARB_BURST0);
    end
  end

  always_ff @(posedge clk_i_fast or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign win0 = req0_i & (~req1_i | ~rr_ptr_d);
`endif

  assign win1 = req1_i & ~win0;

  // ---------------------------------------------------------------------------
  // Grant FSM
  // ---------------------------------------------------------------------------
  assign last_beat = ((state_q == ARB_BURST0) && (beat_cnt_q == LastBeat)) ||
                     (state_q == ARB_BEAT1);
  // Next owner is picked in the last beat too, so grants run back to back.
  assign arb_open  = (state_q == ARB_IDLE) || last_beat;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    if (arb_open) begin
      beat_cnt_d = '0;
      if (win0) begin
        state_d = ARB_BURST0;
      end else if (win1) begin
        state_d = ARB_BEAT1;
      end else begin
        state_d = ARB_IDLE;
      end
    end else if (state_q == ARB_BURST0) begin
      // Burst is locked: continues regardless of req0_i.
      beat_cnt_d = beat_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i_fast or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB_IDLE;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue
  // ---------------------------------------------------------------------------
  mul_id_t issue_id;

  always_comb begin
    gnt0_o   = (state_q == ARB_BURST0);
    gnt1_o   = (state_q == ARB_BEAT1);
    mul_en_o = gnt0_o | gnt1_o;
    issue_id = gnt1_o ? ID_REQ1 : ID_REQ0;
    mul_a_o  = '0;
    mul_b_o  = '0;
    if (gnt0_o) begin
      mul_a_o = a0_i;
      mul_b_o = b0_i;
    end else if (gnt1_o) begin
      mul_a_o = a1_i;
      mul_b_o = b1_i;
    end
  end

  // ---------------------------------------------------------------------------
  // In-flight tracking and response routing
  // ---------------------------------------------------------------------------
  logic    tag_vld;
  mul_id_t tag_id;
  logic    tag_any;

  neur_mul_tag_pipe #(
    .MUL_LAT (MUL_LAT)
  ) u_tag_pipe (
    .clk_i_fast (clk_i_fast),
    .rst_ni     (rst_ni),
    .in_vld     (mul_en_o),
    .in_id      (issue_id),
    .out_vld    (tag_vld),
    .out_id     (tag_id),
    .any_vld    (tag_any)
  );

  logic [NLANES*PRODW-1:0] rsp_p_q;
  logic [1:0]              rsp_vld_q;

  always_ff @(posedge clk_i_fast or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_p_q   <= '0;
      rsp_vld_q <= '0;
    end else begin
      rsp_vld_q <= tag_vld ? id_onehot(tag_id) : 2'b00;
      if (tag_vld) begin
        rsp_p_q <= mul_p_i;
      end
    end
  end

  assign rsp_p_o   = rsp_p_q;
  assign rsp_vld_o = rsp_vld_q;
  assign busy_o    = (state_q != ARB_IDLE) | tag_any;

endmodule

// File: tb/tb_neur_mul_arbiter.sv
// Directed bench for neur_mul_arbiter with a scoreboard: each issued beat pushes its
// expected response; a monitor pops and compares whenever rsp_vld_o is raised.
// Honours NEUR_MUL_ARB_FIXED_PRIO_EN for the arbitration expectations.
module tb_neur_mul_arbiter;

  localparam int NL  = 4;
  localparam int OW  = 17;
  localparam int PW  = 32;
  localparam int LAT = 3;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic            req0, req1;
  logic [NL*OW-1:0] a0, b0, a1, b1;
  logic            gnt0, gnt1, mul_en, busy;
  logic [NL*OW-1:0] mul_a, mul_b;
  logic [NL*PW-1:0] mul_p, rsp_p;
  logic [1:0]      rsp_vld;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]       vld;
    logic [NL*PW-1:0] p;
  } rsp_t;
  rsp_t exp_q[$];

  always #5 clk = ~clk;

  neur_mul_arbiter #(
    .MUL_LAT (LAT),
    .BURST0  (2)
  ) dut (
    .clk_i_fast (clk),
    .rst_ni     (rst_ni),
    .req0_i     (req0),
    .a0_i       (a0),
    .b0_i       (b0),
    .gnt0_o     (gnt0),
    .req1_i     (req1),
    .a1_i       (a1),
    .b1_i       (b1),
    .gnt1_o     (gnt1),
    .mul_a_o    (mul_a),
    .mul_b_o    (mul_b),
    .mul_en_o   (mul_en),
    .mul_p_i    (mul_p),
    .rsp_p_o    (rsp_p),
    .rsp_vld_o  (rsp_vld),
    .busy_o     (busy)
  );

  function automatic logic [NL*OW-1:0] lanes(input int base, input int stride);
    logic [NL*OW-1:0] v;
    for (int i = 0; i < NL; i++) v[i*OW +: OW] = OW'(base + i * stride);
    return v;
  endfunction

  function automatic logic [NL*PW-1:0] prod(input logic [NL*OW-1:0] a, input logic [NL*OW-1:0] b);
    logic [NL*PW-1:0] r;
    logic [63:0]      p;
    for (int i = 0; i < NL; i++) begin
      p = 64'(a[i*OW +: OW]) * 64'(b[i*OW +: OW]);
      r[i*PW +: PW] = p[PW-1:0];
    end
    return r;
  endfunction

  // Multiplier array model: LAT-stage product pipeline.
  logic [NL*PW-1:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= prod(mul_a, mul_b);
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_p = mpipe[LAT-1];

  // Response monitor.
  always @(negedge clk) begin
    rsp_t e;
    if (rsp_vld != 2'b00) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected: got vld=%b p=%h, required no response", rsp_vld, rsp_p);
      end else begin
        e = exp_q.pop_front();
        if (rsp_vld !== e.vld || rsp_p !== e.p) begin
          bad++;
          $display("FAIL rsp_data: got vld=%b p=%h, required vld=%b p=%h",
                   rsp_vld, rsp_p, e.vld, e.p);
        end
      end
    end
  end

  task automatic step(input logic r0, input logic r1,
                      input logic [NL*OW-1:0] a0v, input logic [NL*OW-1:0] b0v,
                      input logic [NL*OW-1:0] a1v, input logic [NL*OW-1:0] b1v,
                      input logic eg0, input logic eg1, input string nm);
    rsp_t e;
    req0 = r0; req1 = r1;
    a0 = a0v; b0 = b0v; a1 = a1v; b1 = b1v;
    @(negedge clk);
    total++;
    if ({gnt0, gnt1, mul_en} !== {eg0, eg1, eg0 | eg1}) begin
      bad++;
      $display("FAIL %s grant: got gnt0,gnt1,en=%b%b%b required %b%b%b",
               nm, gnt0, gnt1, mul_en, eg0, eg1, eg0 | eg1);
    end
    total++;
    if (!eg0 && !eg1) begin
      if (mul_a !== '0 || mul_b !== '0) begin
        bad++;
        $display("FAIL %s idle_ops: got a=%h b=%h required 0", nm, mul_a, mul_b);
      end
    end else if (mul_a !== (eg0 ? a0v : a1v) || mul_b !== (eg0 ? b0v : b1v)) begin
      bad++;
      $display("FAIL %s ops: got a=%h b=%h required a=%h b=%h",
               nm, mul_a, mul_b, eg0 ? a0v : a1v, eg0 ? b0v : b1v);
    end
    if (eg0) begin
      e.vld = 2'b01; e.p = prod(a0v, b0v); exp_q.push_back(e);
    end
    if (eg1) begin
      e.vld = 2'b10; e.p = prod(a1v, b1v); exp_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input string nm);
    step(1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, nm);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s drain: got pending=%0d busy=%b required 0 and 0", nm, exp_q.size(), busy);
    end
  endtask

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0;
    rst_ni = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  logic [1:0] exp_g [12];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    rst_ni = 1'b0;
    @(negedge clk);
    total++;
    if ({gnt0, gnt1, mul_en, rsp_vld, busy} !== 6'b0 || rsp_p !== '0 ||
        mul_a !== '0 || mul_b !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got gnt=%b%b en=%b vld=%b busy=%b p=%h required all 0",
               gnt0, gnt1, mul_en, rsp_vld, busy, rsp_p);
    end
    @(posedge clk); #1 rst_ni = 1'b1;

    // req0 alone, lanes 3*3
    step(1, 0, lanes(3, 0), lanes(3, 0), '0, '0, 0, 0, "t1_arb");
    step(1, 0, lanes(3, 0), lanes(3, 0), '0, '0, 1, 0, "t1_b0");
    step(0, 0, lanes(3, 0), lanes(3, 0), '0, '0, 1, 0, "t1_b1");
    idle("t1_idle");
    drain("t1");

    // Contention right after reset
    do_reset();
    step(1, 1, lanes(5, 1), lanes(7, 2), lanes(100, 3), lanes(9, 1), 0, 0, "t2_arb");
    step(1, 1, lanes(6, 1), lanes(8, 2), lanes(101, 3), lanes(9, 1), 1, 0, "t2_b0");
`ifdef NEUR_MUL_ARB_FIXED_PRIO_EN
    step(0, 1, lanes(7, 1), lanes(9, 2), lanes(102, 3), lanes(9, 1), 1, 0, "t2_b1");
    step(0, 0, lanes(8, 1), lanes(9, 2), lanes(103, 3), lanes(11, 1), 0, 1, "t2_g1");
`else
    step(1, 1, lanes(7, 1), lanes(9, 2), lanes(102, 3), lanes(9, 1), 1, 0, "t2_b1");
    step(0, 0, lanes(8, 1), lanes(9, 2), lanes(103, 3), lanes(11, 1), 0, 1, "t2_g1");
`endif
    idle("t2_idle");
    drain("t2");

    // req1 held: a beat every cycle, 17-bit max operands
    step(0, 1, '0, '0, {17'd4, 17'd3, 17'h1FFFF, 17'h1FFFF}, {17'd5, 17'd6, 17'h1FFFF, 17'd2},
         0, 0, "t3_arb");
    step(0, 1, '0, '0, {17'd4, 17'd3, 17'h1FFFF, 17'h1FFFF}, {17'd5, 17'd6, 17'h1FFFF, 17'd2},
         0, 1, "t3_g0");
    step(0, 1, '0, '0, lanes(1000, 17), lanes(77, 5), 0, 1, "t3_g1");
    step(0, 0, '0, '0, lanes(131071, 0), lanes(131071, 0), 0, 1, "t3_g2");
    idle("t3_idle");
    drain("t3");

    // req0 dropped during beat 0: burst still completes
    step(1, 0, lanes(5, 0), lanes(7, 0), '0, '0, 0, 0, "t4_arb");
    step(0, 0, lanes(5, 0), lanes(7, 0), '0, '0, 1, 0, "t4_b0");
    step(0, 0, lanes(2, 0), lanes(11, 0), '0, '0, 1, 0, "t4_b1");
    idle("t4_idle");
    drain("t4");

    // Both held continuously
    do_reset();
`ifdef NEUR_MUL_ARB_FIXED_PRIO_EN
    exp_g = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
              2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
`else
    exp_g = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01,
              2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b00};
`endif
    step(1, 1, lanes(1, 1), lanes(2, 3), lanes(100, 2), lanes(1, 1), 0, 0, "t6_arb");
    for (int k = 0; k < 12; k++) begin
      step(k < 9, k < 9, lanes(k + 1, 1), lanes(k + 2, 3), lanes(100 + k, 2), lanes(k * 7 + 1, 1),
           exp_g[k][1], exp_g[k][0], $sformatf("t6_c%0d", k));
    end
    drain("t6");

    // Reset with three beats in flight
    do_reset();
    step(1, 1, lanes(4, 1), lanes(4, 1), lanes(9, 1), lanes(9, 1), 0, 0, "t5_arb");
    step(1, 1, lanes(4, 1), lanes(4, 1), lanes(9, 1), lanes(9, 1), 1, 0, "t5_b0");
    step(0, 1, lanes(4, 1), lanes(4, 1), lanes(9, 1), lanes(9, 1), 1, 0, "t5_b1");
    step(0, 0, lanes(4, 1), lanes(4, 1), lanes(9, 1), lanes(9, 1), 0, 1, "t5_g1");
    total++;
    if (busy !== 1'b1 || rsp_vld !== 2'b00) begin
      bad++;
      $display("FAIL t5_inflight: got busy=%b vld=%b required 1 and 00", busy, rsp_vld);
    end
    rst_ni = 1'b0;
    exp_q.delete();
    #1;
    total++;
    if (busy !== 1'b0 || rsp_vld !== 2'b00) begin
      bad++;
      $display("FAIL t5_in_reset: got busy=%b vld=%b required 0 and 00", busy, rsp_vld);
    end
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || rsp_vld !== 2'b00 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL t5_after_reset: got busy=%b vld=%b required 0 and 00", busy, rsp_vld);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
